// File: rtl/tmu_config_scheduler_pkg.sv
// Shared constants and FSM encoding for the TMU configuration scheduler.
package tmu_config_scheduler_pkg;

    localparam int TMU_DEPTH             = 14;
    // Two credits of margin over the TMU pipeline depth.
    localparam int DEFAULT_MAX_IN_FLIGHT = TMU_DEPTH + 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2
    } sched_state_e;

endpackage

// File: rtl/tmu_config_scheduler_if.sv
// Config port, fragment handshake, TMU retire observation and conf* outputs.
interface tmu_config_scheduler_if #(
    parameter int PIXEL_WIDTH = 32
);
    logic                   s_cfg_valid;
    logic                   s_cfg_ready;
    logic [31:0]            s_cfg_func;
    logic [PIXEL_WIDTH-1:0] s_cfg_env_color;
    logic [31:0]            s_cfg_texture_config;
    logic                   s_cfg_enable;
    logic [31:0]            confFunc;
    logic [PIXEL_WIDTH-1:0] confTextureEnvColor;
    logic [31:0]            confTextureConfig;
    logic                   confEnable;
    logic                   s_frag_valid;
    logic                   s_frag_ready;
    logic                   m_frag_valid;
    logic                   m_frag_ready;
    logic                   tmu_out_valid;
    logic                   tmu_out_ready;
    logic                   busy;
    logic                   err_underflow;

    modport master (
        output s_cfg_valid, s_cfg_func, s_cfg_env_color, s_cfg_texture_config, s_cfg_enable,
        output s_frag_valid, m_frag_ready, tmu_out_valid, tmu_out_ready,
        input  s_cfg_ready, confFunc, confTextureEnvColor, confTextureConfig, confEnable,
        input  s_frag_ready, m_frag_valid, busy, err_underflow
    );

    modport slave (
        input  s_cfg_valid, s_cfg_func, s_cfg_env_color, s_cfg_texture_config, s_cfg_enable,
        input  s_frag_valid, m_frag_ready, tmu_out_valid, tmu_out_ready,
        output s_cfg_ready, confFunc, confTextureEnvColor, confTextureConfig, confEnable,
        output s_frag_ready, m_frag_valid, busy, err_underflow
    );

endinterface

// File: rtl/tmu_config_scheduler_inflight_counter.sv
// Up/down credit counter for fragments inside the TMU, with sticky underflow flag.
module tmu_inflight_counter #(
    parameter int MAX_COUNT = 16,
    parameter int CNT_WIDTH = $clog2(MAX_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] count_next,
    output logic                 full,
    output logic                 underflow
);
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(MAX_COUNT);

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 underflow_q, underflow_d;

    always_comb begin
        count_d     = count_q;
        underflow_d = underflow_q;
        if (inc && !dec && count_q != LIMIT) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc) begin
            // A retire with nothing outstanding is a protocol error; hold at zero.
            if (count_q == '0) underflow_d = 1'b1;
            else               count_d     = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign count_next = count_d;
    assign full       = (count_q == LIMIT);
    assign underflow  = underflow_q;

endmodule

// File: rtl/tmu_config_scheduler.sv
// Holds a pending TMU config, closes the fragment gate, drains in-flight work, then swaps conf*.
module tmu_config_scheduler
    import tmu_config_scheduler_pkg::*;
#(
    parameter int PIXEL_WIDTH   = 32,
    parameter int MAX_IN_FLIGHT = DEFAULT_MAX_IN_FLIGHT
) (
    input logic                   aclk,
    input logic                   reset,
    tmu_config_scheduler_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(MAX_IN_FLIGHT + 1);

    sched_state_e           state_q, state_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [31:0]            pend_func_q, pend_func_d, pend_tex_q, pend_tex_d;
    logic [PIXEL_WIDTH-1:0] pend_color_q, pend_color_d;
    logic                   pend_en_q, pend_en_d;
    logic [31:0]            conf_func_q, conf_func_d, conf_tex_q, conf_tex_d;
    logic [PIXEL_WIDTH-1:0] conf_color_q, conf_color_d;
    logic                   conf_en_q, conf_en_d;
    logic [CNT_WIDTH-1:0]   count_next;
    logic                   full, underflow;
    logic                   gate_open, cfg_ready, cfg_acc, frag_acc, retire;

    assign cfg_ready = (state_q == ST_RUN) && !pend_valid_q;
    assign gate_open = cfg_ready && !full;
    assign cfg_acc   = bus.s_cfg_valid && cfg_ready;
    assign frag_acc  = bus.s_frag_valid && bus.m_frag_ready && gate_open;
    assign retire    = bus.tmu_out_valid && bus.tmu_out_ready;

    tmu_inflight_counter #(
        .MAX_COUNT (MAX_IN_FLIGHT),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk        (aclk),
        .reset      (reset),
        .inc        (frag_acc),
        .dec        (retire),
        .count_next (count_next),
        .full       (full),
        .underflow  (underflow)
    );

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_func_d  = pend_func_q;
        pend_color_d = pend_color_q;
        pend_tex_d   = pend_tex_q;
        pend_en_d    = pend_en_q;
        conf_func_d  = conf_func_q;
        conf_color_d = conf_color_q;
        conf_tex_d   = conf_tex_q;
        conf_en_d    = conf_en_q;
        if (cfg_acc) begin
            pend_valid_d = 1'b1;
            pend_func_d  = bus.s_cfg_func;
            pend_color_d = bus.s_cfg_env_color;
            pend_tex_d   = bus.s_cfg_texture_config;
            pend_en_d    = bus.s_cfg_enable;
        end
        unique case (state_q)
            // Leave RUN together with the capture so the gate is shut from the next cycle.
            ST_RUN:   if (pend_valid_d) state_d = ST_DRAIN;
            ST_DRAIN: if (count_next == '0) state_d = ST_APPLY;
            ST_APPLY: begin
                conf_func_d  = pend_func_q;
                conf_color_d = pend_color_q;
                conf_tex_d   = pend_tex_q;
                conf_en_d    = pend_en_q;
                pend_valid_d = 1'b0;
                state_d      = ST_RUN;
            end
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pend_valid_q <= 1'b0;
            pend_func_q  <= '0;
            pend_color_q <= '0;
            pend_tex_q   <= '0;
            pend_en_q    <= 1'b0;
            conf_func_q  <= '0;
            conf_color_q <= '0;
            conf_tex_q   <= '0;
            conf_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_func_q  <= pend_func_d;
            pend_color_q <= pend_color_d;
            pend_tex_q   <= pend_tex_d;
            pend_en_q    <= pend_en_d;
            conf_func_q  <= conf_func_d;
            conf_color_q <= conf_color_d;
            conf_tex_q   <= conf_tex_d;
            conf_en_q    <= conf_en_d;
        end
    end

    assign bus.s_cfg_ready         = cfg_ready;
    assign bus.m_frag_valid        = bus.s_frag_valid && gate_open;
    assign bus.s_frag_ready        = bus.m_frag_ready && gate_open;
    assign bus.confFunc            = conf_func_q;
    assign bus.confTextureEnvColor = conf_color_q;
    assign bus.confTextureConfig   = conf_tex_q;
    assign bus.confEnable          = conf_en_q;
    assign bus.busy                = (state_q != ST_RUN) || pend_valid_q;
    assign bus.err_underflow       = underflow;

endmodule

// File: tb/tb_tmu_config_scheduler.sv
// Randomized bench for tmu_config_scheduler against a cycle-level behavioural model.
module tb_tmu_config_scheduler;
    localparam int PW   = 32;
    localparam int MAXF = 16;

    logic aclk = 1'b0;
    logic reset;
    always #5 aclk = ~aclk;

    tmu_config_scheduler_if #(.PIXEL_WIDTH(PW)) bus ();
    tmu_config_scheduler #(.PIXEL_WIDTH(PW), .MAX_IN_FLIGHT(MAXF)) dut (
        .aclk  (aclk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0]   func;
        logic [PW-1:0] color;
        logic [31:0]   tex;
        logic          en;
    } cfg_t;

    int n_cmp = 0;
    int n_err = 0;

    // Model: outstanding fragments, pending config and the cycle at which it becomes visible.
    int   cyc = 0;
    int   m_cnt, m_apply_at;
    bit   m_pend, m_err;
    cfg_t m_pcfg, m_conf;
    logic [9:0] exp_obs;
    cfg_t exp_conf;

    function automatic logic [9:0] obs();
        return {5'(dut.u_cnt.count_q), bus.s_frag_ready, bus.m_frag_valid,
                bus.s_cfg_ready, bus.busy, bus.err_underflow};
    endfunction

    function automatic cfg_t conf_now();
        return {bus.confFunc, bus.confTextureEnvColor, bus.confTextureConfig, bus.confEnable};
    endfunction

    function automatic cfg_t cfg_in();
        return {bus.s_cfg_func, bus.s_cfg_env_color, bus.s_cfg_texture_config, bus.s_cfg_enable};
    endfunction

    task automatic drive_cfg(input bit v, input cfg_t c);
        bus.s_cfg_valid          = v;
        bus.s_cfg_func           = c.func;
        bus.s_cfg_env_color      = c.color;
        bus.s_cfg_texture_config = c.tex;
        bus.s_cfg_enable         = c.en;
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.func = $urandom; c.color = $urandom; c.tex = $urandom; c.en = 1'($urandom);
        return c;
    endfunction

    task automatic settle();
        bit open;
        #1;
        open     = !m_pend && (m_cnt < MAXF);
        exp_obs  = {5'(m_cnt), bus.m_frag_ready && open, bus.s_frag_valid && open,
                    !m_pend, m_pend, m_err};
        exp_conf = m_conf;
    endtask

    task automatic advance();
        bit   ret, acc, cacc;
        cfg_t cin;
        int   nxt, c0;
        ret  = bus.tmu_out_valid && bus.tmu_out_ready;
        acc  = bus.s_frag_valid && bus.m_frag_ready && !m_pend && (m_cnt < MAXF);
        cacc = bus.s_cfg_valid && !m_pend;
        cin  = cfg_in();
        c0   = cyc;
        @(posedge aclk);
        cyc = cyc + 1;
        if (reset) begin
            m_cnt = 0; m_pend = 0; m_err = 0; m_conf = '0; m_pcfg = '0; m_apply_at = -1;
        end else begin
            nxt = m_cnt;
            if (acc && !ret) nxt++;
            else if (ret && !acc) begin
                if (m_cnt == 0) m_err = 1; else nxt--;
            end
            // Once drained (with a pending config already registered), conf* switches two cycles later.
            if (m_pend && m_apply_at < 0 && nxt == 0) m_apply_at = c0 + 2;
            m_cnt = nxt;
            if (cacc) begin m_pend = 1; m_pcfg = cin; end
            if (m_apply_at == cyc) begin m_conf = m_pcfg; m_pend = 0; m_apply_at = -1; end
        end
        @(negedge aclk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        advance(); advance();
        reset = 1'b0;
        settle();
        n_cmp++; if (obs() !== exp_obs) begin n_err++; $display("FAIL reset.obs got=%h want=%h", obs(), exp_obs); end
        n_cmp++; if (conf_now() !== '0) begin n_err++; $display("FAIL reset.conf got=%h want=0", conf_now()); end
        bus.s_frag_valid = 1'b1; bus.m_frag_ready = 1'b1;
        settle();
        n_cmp++; if (bus.s_frag_ready !== 1'b1 || bus.m_frag_valid !== 1'b1) begin
            n_err++; $display("FAIL reset.pass got=%b%b want=11", bus.s_frag_ready, bus.m_frag_valid); end
        advance();
        bus.s_frag_valid = 1'b0; bus.tmu_out_valid = 1'b1; bus.tmu_out_ready = 1'b1;
        settle();
        n_cmp++; if (obs() !== exp_obs) begin n_err++; $display("FAIL reset.retire got=%h want=%h", obs(), exp_obs); end
        advance();
        bus.tmu_out_valid = 1'b0;
    endtask

    task automatic test_cfg_empty();
        cfg_t c;
        c = rand_cfg(); c.func = 32'h0000_0123;
        bus.m_frag_ready = 1'b1;
        drive_cfg(1'b1, c);
        settle();
        n_cmp++; if (bus.s_cfg_ready !== 1'b1) begin n_err++; $display("FAIL cfg_empty.ready got=%b want=1", bus.s_cfg_ready); end
        advance();
        bus.s_cfg_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            settle();
            n_cmp++; if (obs() !== exp_obs) begin n_err++; $display("FAIL cfg_empty.obs k=%0d got=%h want=%h", k, obs(), exp_obs); end
            n_cmp++; if (conf_now() !== exp_conf) begin n_err++; $display("FAIL cfg_empty.conf k=%0d got=%h want=%h", k, conf_now(), exp_conf); end
            if (k < 3) begin
                n_cmp++; if (bus.s_frag_ready !== 1'b0) begin n_err++; $display("FAIL cfg_empty.gate k=%0d got=%b want=0", k, bus.s_frag_ready); end
            end else begin
                n_cmp++; if (bus.confFunc !== 32'h123) begin n_err++; $display("FAIL cfg_empty.func k=%0d got=%h want=123", k, bus.confFunc); end
            end
            advance();
        end
    endtask

    task automatic test_traffic();
        int   switches;
        cfg_t prev;
        switches = 0;
        prev = conf_now();
        for (int k = 0; k < 25; k++) begin
            bus.s_frag_valid  = (k < 5) || (k >= 6 && k < 16);
            bus.m_frag_ready  = 1'b1;
            bus.tmu_out_valid = (k >= 16 && k < 21);
            bus.tmu_out_ready = bus.tmu_out_valid;
            drive_cfg(k == 5, rand_cfg());
            settle();
            n_cmp++; if (obs() !== exp_obs) begin n_err++; $display("FAIL traffic.obs k=%0d got=%h want=%h", k, obs(), exp_obs); end
            n_cmp++; if (conf_now() !== exp_conf) begin n_err++; $display("FAIL traffic.conf k=%0d got=%h want=%h", k, conf_now(), exp_conf); end
            if (conf_now() !== prev) switches++;
            prev = conf_now();
            advance();
        end
        bus.tmu_out_valid = 1'b0; bus.tmu_out_ready = 1'b0; bus.s_cfg_valid = 1'b0;
        n_cmp++; if (switches != 1) begin n_err++; $display("FAIL traffic.switches got=%0d want=1", switches); end
    endtask

    task automatic test_credit_limit();
        int accepts;
        accepts = 0;
        bus.s_frag_valid = 1'b1; bus.m_frag_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            settle();
            n_cmp++; if (obs() !== exp_obs) begin n_err++; $display("FAIL credit.obs k=%0d got=%h want=%h", k, obs(), exp_obs); end
            if (bus.m_frag_valid && bus.m_frag_ready) accepts++;
            advance();
        end
        n_cmp++; if (accepts != MAXF) begin n_err++; $display("FAIL credit.accepts got=%0d want=%0d", accepts, MAXF); end
        accepts = 0;
        for (int k = 0; k < 3; k++) begin
            bus.tmu_out_valid = (k == 0); bus.tmu_out_ready = (k == 0);
            settle();
            n_cmp++; if (obs() !== exp_obs) begin n_err++; $display("FAIL credit.refill k=%0d got=%h want=%h", k, obs(), exp_obs); end
            if (bus.m_frag_valid && bus.m_frag_ready) accepts++;
            advance();
        end
        n_cmp++; if (accepts != 1) begin n_err++; $display("FAIL credit.refill_accepts got=%0d want=1", accepts); end
        bus.s_frag_valid = 1'b0; bus.tmu_out_valid = 1'b1; bus.tmu_out_ready = 1'b1;
        for (int k = 0; k < MAXF; k++) begin
            settle();
            n_cmp++; if (obs() !== exp_obs) begin n_err++; $display("FAIL credit.drain k=%0d got=%h want=%h", k, obs(), exp_obs); end
            advance();
        end
        bus.tmu_out_valid = 1'b0; bus.tmu_out_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        cfg_t a, b;
        int   acc_n, k0;
        a = rand_cfg(); b = rand_cfg();
        bus.s_frag_valid = 1'b1; bus.m_frag_ready = 1'b1;
        repeat (3) advance();
        bus.tmu_out_valid = 1'b1; bus.tmu_out_ready = 1'b1;
        settle();
        n_cmp++; if (obs() !== exp_obs) begin n_err++; $display("FAIL simul.both got=%h want=%h", obs(), exp_obs); end
        advance();
        bus.s_frag_valid = 1'b0; bus.tmu_out_valid = 1'b0; bus.tmu_out_ready = 1'b0;
        settle();
        n_cmp++; if (dut.u_cnt.count_q !== 5'd3) begin n_err++; $display("FAIL simul.count got=%0d want=3", dut.u_cnt.count_q); end
        acc_n = 0; k0 = -1;
        drive_cfg(1'b1, a);
        for (int k = 0; k < 16; k++) begin
            bus.tmu_out_valid = (k0 >= 0 && k - k0 < 3); bus.tmu_out_ready = bus.tmu_out_valid;
            settle();
            n_cmp++; if (obs() !== exp_obs) begin n_err++; $display("FAIL simul.obs k=%0d got=%h want=%h", k, obs(), exp_obs); end
            n_cmp++; if (conf_now() !== exp_conf) begin n_err++; $display("FAIL simul.conf k=%0d got=%h want=%h", k, conf_now(), exp_conf); end
            if (bus.s_cfg_valid && bus.s_cfg_ready) begin acc_n++; if (k0 < 0) k0 = k + 1; end
            advance();
            if (acc_n == 1) drive_cfg(1'b1, b);
            else if (acc_n == 2) bus.s_cfg_valid = 1'b0;
        end
        bus.tmu_out_valid = 1'b0; bus.tmu_out_ready = 1'b0; bus.s_cfg_valid = 1'b0;
        n_cmp++; if (conf_now() !== b) begin n_err++; $display("FAIL simul.final got=%h want=%h", conf_now(), b); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            bus.s_frag_valid  = 1'($urandom);
            bus.m_frag_ready  = ($urandom_range(3) != 0);
            bus.tmu_out_valid = (m_cnt > 0) && 1'($urandom);
            bus.tmu_out_ready = ($urandom_range(3) != 0);
            drive_cfg($urandom_range(7) == 0, rand_cfg());
            settle();
            n_cmp++; if (obs() !== exp_obs) begin n_err++; $display("FAIL random.obs k=%0d got=%h want=%h", k, obs(), exp_obs); end
            n_cmp++; if (conf_now() !== exp_conf) begin n_err++; $display("FAIL random.conf k=%0d got=%h want=%h", k, conf_now(), exp_conf); end
            advance();
        end
        bus.s_frag_valid = 1'b0; bus.s_cfg_valid = 1'b0; bus.tmu_out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.tmu_out_valid = (m_cnt > 0);
            settle();
            n_cmp++; if (obs() !== exp_obs) begin n_err++; $display("FAIL random.drain k=%0d got=%h want=%h", k, obs(), exp_obs); end
            advance();
        end
        bus.tmu_out_valid = 1'b0; bus.tmu_out_ready = 1'b0;
    endtask

    task automatic test_underflow_reset();
        bus.tmu_out_valid = 1'b1; bus.tmu_out_ready = 1'b1;
        advance();
        bus.tmu_out_valid = 1'b0; bus.tmu_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            n_cmp++; if (bus.err_underflow !== 1'b1) begin n_err++; $display("FAIL underflow.sticky k=%0d got=%b want=1", k, bus.err_underflow); end
            n_cmp++; if (obs() !== exp_obs) begin n_err++; $display("FAIL underflow.obs k=%0d got=%h want=%h", k, obs(), exp_obs); end
            advance();
        end
        bus.s_frag_valid = 1'b1; bus.m_frag_ready = 1'b1;
        advance(); advance();
        bus.s_frag_valid = 1'b0;
        drive_cfg(1'b1, rand_cfg());
        advance();
        bus.s_cfg_valid = 1'b0;
        reset = 1'b1;
        settle();
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL midreset.busy got=%b want=1", bus.busy); end
        advance();
        reset = 1'b0;
        settle();
        n_cmp++; if (obs() !== exp_obs) begin n_err++; $display("FAIL midreset.obs got=%h want=%h", obs(), exp_obs); end
        n_cmp++; if (conf_now() !== '0 || bus.err_underflow !== 1'b0) begin
            n_err++; $display("FAIL midreset.clear conf=%h err=%b want conf=0 err=0", conf_now(), bus.err_underflow); end
        advance();
    endtask

    initial begin
        reset = 1'b1;
        drive_cfg(1'b0, '0);
        bus.s_frag_valid = 1'b0; bus.m_frag_ready = 1'b0;
        bus.tmu_out_valid = 1'b0; bus.tmu_out_ready = 1'b0;
        m_cnt = 0; m_pend = 0; m_err = 0; m_conf = '0; m_pcfg = '0; m_apply_at = -1;
        @(negedge aclk);
        test_reset();
        test_cfg_empty();
        test_traffic();
        test_credit_limit();
        test_simultaneous();
        test_random();
        test_underflow_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
